// File: rtl/d_latch_monitor.sv
// d_latch_monitor: clocked checker for an enable/reset D latch.
// Inputs: clk, rst, mon_d/en/rstn/q, clr. Outputs: exp_q, checking, err,
// err_sticky, fail, mismatch_cnt, toggle_cnt (saturating, CNT_W bits).
module d_latch_monitor #(
  parameter int CNT_W       = 8,
  parameter int LAT         = 1,
  parameter int STOP_ON_ERR = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mon_d,
  input  logic             mon_en,
  input  logic             mon_rstn,
  input  logic             mon_q,
  input  logic             clr,
  output logic             exp_q,
  output logic             checking,
  output logic             err,
  output logic             err_sticky,
  output logic             fail,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [CNT_W-1:0] toggle_cnt
);

  generate
    if (LAT < 1 || LAT > 4) begin : g_bad_lat
      $error("d_latch_monitor: LAT must be in 1..4");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_UNKNOWN = 2'd0,
    S_CHECK   = 2'd1,
    S_FAIL    = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CMAX = '1;

  state_t         state;
  state_t         state_nx;
  logic           m;
  logic           k;
  logic           prev_en;
  logic [LAT-1:0] mp;
  logic [LAT-1:0] kp;
  logic           m_nx;
  logic           k_nx;
  logic           mismatch;
  logic           toggle;

  // Reference latch: reset beats enable, otherwise hold.
  always_comb begin
    m_nx = m;
    k_nx = k;
    if (!mon_rstn) begin
      m_nx = 1'b0;
      k_nx = 1'b1;
    end else if (mon_en) begin
      m_nx = mon_d;
      k_nx = 1'b1;
    end
  end

  assign exp_q    = mp[LAT-1];
  assign mismatch = (state == S_CHECK) && (mon_q != mp[LAT-1]);
  assign toggle   = (state != S_FAIL) && (mon_en != prev_en);

  always_comb begin
    state_nx = state;
    unique case (state)
      S_UNKNOWN: if (kp[LAT-1]) state_nx = S_CHECK;
      S_CHECK:   if (mismatch && STOP_ON_ERR != 0) state_nx = S_FAIL;
      default:   state_nx = state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_UNKNOWN;
      m            <= 1'b0;
      k            <= 1'b0;
      prev_en      <= 1'b0;
      mp           <= '0;
      kp           <= '0;
      checking     <= 1'b0;
      err          <= 1'b0;
      err_sticky   <= 1'b0;
      fail         <= 1'b0;
      mismatch_cnt <= '0;
      toggle_cnt   <= '0;
    end else begin
      state    <= state_nx;
      checking <= (state_nx == S_CHECK);
      fail     <= (state_nx == S_FAIL);
      prev_en  <= mon_en;
      err      <= mismatch;
      // FAIL freezes the model so exp_q holds its last value.
      if (state != S_FAIL) begin
        m <= m_nx;
        k <= k_nx;
        for (int i = LAT - 1; i > 0; i--) begin
          mp[i] <= mp[i-1];
          kp[i] <= kp[i-1];
        end
        mp[0] <= m_nx;
        kp[0] <= k_nx;
      end
      if (clr) begin
        err_sticky   <= 1'b0;
        mismatch_cnt <= '0;
        toggle_cnt   <= '0;
      end else begin
        if (mismatch) begin
          err_sticky <= 1'b1;
          if (mismatch_cnt != CMAX)
            mismatch_cnt <= mismatch_cnt + 1'b1;
        end
        if (toggle && toggle_cnt != CMAX)
          toggle_cnt <= toggle_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_d_latch_monitor.sv
// tb_d_latch_monitor: randomized and directed checks of d_latch_monitor
// against a per-edge history model of the latch.
module tb_d_latch_monitor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mon_d = 1'b0;
  logic mon_en = 1'b0;
  logic mon_rstn = 1'b1;
  logic mon_q = 1'b0;
  logic clr = 1'b0;

  always #5 clk = ~clk;

  logic       a_exp, a_chk, a_err, a_st, a_fail;
  logic [7:0] a_mc, a_tc;
  logic       b_exp, b_chk, b_err, b_st, b_fail;
  logic [1:0] b_mc, b_tc;
  logic       c_exp, c_chk, c_err, c_st, c_fail;
  logic [7:0] c_mc, c_tc;
  logic       e_exp, e_chk, e_err, e_st, e_fail;
  logic [7:0] e_mc, e_tc;

  d_latch_monitor #(.CNT_W(8), .LAT(1), .STOP_ON_ERR(0)) u_a (
    .clk(clk), .rst(rst), .mon_d(mon_d), .mon_en(mon_en),
    .mon_rstn(mon_rstn), .mon_q(mon_q), .clr(clr),
    .exp_q(a_exp), .checking(a_chk), .err(a_err), .err_sticky(a_st),
    .fail(a_fail), .mismatch_cnt(a_mc), .toggle_cnt(a_tc));

  d_latch_monitor #(.CNT_W(2), .LAT(1), .STOP_ON_ERR(0)) u_b (
    .clk(clk), .rst(rst), .mon_d(mon_d), .mon_en(mon_en),
    .mon_rstn(mon_rstn), .mon_q(mon_q), .clr(clr),
    .exp_q(b_exp), .checking(b_chk), .err(b_err), .err_sticky(b_st),
    .fail(b_fail), .mismatch_cnt(b_mc), .toggle_cnt(b_tc));

  d_latch_monitor #(.CNT_W(8), .LAT(1), .STOP_ON_ERR(1)) u_c (
    .clk(clk), .rst(rst), .mon_d(mon_d), .mon_en(mon_en),
    .mon_rstn(mon_rstn), .mon_q(mon_q), .clr(clr),
    .exp_q(c_exp), .checking(c_chk), .err(c_err), .err_sticky(c_st),
    .fail(c_fail), .mismatch_cnt(c_mc), .toggle_cnt(c_tc));

  d_latch_monitor #(.CNT_W(8), .LAT(3), .STOP_ON_ERR(0)) u_e (
    .clk(clk), .rst(rst), .mon_d(mon_d), .mon_en(mon_en),
    .mon_rstn(mon_rstn), .mon_q(mon_q), .clr(clr),
    .exp_q(e_exp), .checking(e_chk), .err(e_err), .err_sticky(e_st),
    .fail(e_fail), .mismatch_cnt(e_mc), .toggle_cnt(e_tc));

  int tests = 0;
  int fails = 0;

  // History of the ideal latch after edge n since reset (n=0 is reset).
  int n;
  bit mv[0:4095];
  bit kn[0:4095];
  bit enh[0:4095];
  int mm1, mm3, tg;
  bit st1, st3, er1, er3;

  function automatic bit mva(int j);
    return (j < 1) ? 1'b0 : mv[j];
  endfunction

  function automatic bit kna(int j);
    return (j < 1) ? 1'b0 : kn[j];
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      n = 0; mv[0] = 0; kn[0] = 0; enh[0] = 0;
      mm1 = 0; mm3 = 0; tg = 0;
      st1 = 0; st3 = 0; er1 = 0; er3 = 0;
    end else begin
      n++;
      enh[n] = mon_en;
      if (!mon_rstn) begin
        mv[n] = 0; kn[n] = 1;
      end else if (mon_en) begin
        mv[n] = mon_d; kn[n] = 1;
      end else begin
        mv[n] = mv[n-1]; kn[n] = kn[n-1];
      end
      // Compare at edge n is live once the model from n-1-L was known.
      er1 = kna(n - 2) && (mon_q != mva(n - 1));
      er3 = kna(n - 4) && (mon_q != mva(n - 3));
      if (clr) begin
        mm1 = 0; mm3 = 0; tg = 0; st1 = 0; st3 = 0;
      end else begin
        if (er1) begin st1 = 1; if (mm1 < 255) mm1++; end
        if (er3) begin st3 = 1; if (mm3 < 255) mm3++; end
        if (enh[n] != enh[n-1] && tg < 255) tg++;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    mon_en = 0; mon_rstn = 1; mon_d = 1; mon_q = 1; clr = 1;
    do_reset();
    clr = 0;
    tests++;
    if ({a_exp, a_chk, a_err, a_st, a_fail, a_mc, a_tc} !== 21'd0) begin
      fails++;
      $display("FAIL reset_a: got %h want 0",
               {a_exp, a_chk, a_err, a_st, a_fail, a_mc, a_tc});
    end
    tests++;
    if ({c_fail, c_chk, e_chk, b_mc} !== 5'd0) begin
      fails++;
      $display("FAIL reset_others: got %b want 0",
               {c_fail, c_chk, e_chk, b_mc});
    end
    for (int i = 0; i < 10; i++) begin
      mon_d = i[0];
      tick();
    end
    tests++;
    if (a_chk !== 1'b0) begin
      fails++;
      $display("FAIL stay_unknown: got %b want 0", a_chk);
    end
  endtask

  task automatic test_known();
    do_reset();
    mon_q = 0; mon_en = 0; mon_rstn = 0;
    tick();
    tests++;
    if (a_chk !== 1'b0) begin
      fails++;
      $display("FAIL known_edge1: got %b want 0", a_chk);
    end
    mon_rstn = 1;
    tick();
    tests++;
    if (a_chk !== 1'b1 || a_mc !== 8'd0) begin
      fails++;
      $display("FAIL known_edge2: got chk=%b cnt=%0d want 1/0", a_chk, a_mc);
    end
  endtask

  task automatic test_follow();
    do_reset();
    mon_rstn = 0; mon_en = 0; mon_q = 0;
    tick();
    mon_rstn = 1; mon_en = 1; mon_d = 0;
    tick();
    mon_q = mv[n]; mon_d = 1;
    tick();
    for (int i = 0; i < 3; i++) begin
      mon_q = mv[n];
      tick();
      tests++;
      if (a_err !== 1'b0 || a_exp !== 1'b1) begin
        fails++;
        $display("FAIL follow_%0d: got err=%b exp=%b want 0/1", i, a_err, a_exp);
      end
    end
    mon_q = 0;
    tick();
    tests++;
    if (a_err !== 1'b1 || a_mc !== 8'd1 || a_st !== 1'b1) begin
      fails++;
      $display("FAIL forced_mismatch: got err=%b cnt=%0d st=%b want 1/1/1",
               a_err, a_mc, a_st);
    end
    mon_q = 1;
    tick();
    tests++;
    if (a_err !== 1'b0 || a_st !== 1'b1) begin
      fails++;
      $display("FAIL err_pulse: got err=%b st=%b want 0/1", a_err, a_st);
    end
  endtask

  task automatic test_toggle();
    clr = 1;
    mon_q = mv[n];
    tick();
    clr = 0;
    for (int i = 0; i < 5; i++) begin
      mon_en = ~mon_en;
      mon_d = i[0];
      tick();
      mon_q = mv[n];
      tests++;
      if (a_err !== 1'b0) begin
        fails++;
        $display("FAIL toggle_err_%0d: got %b want 0", i, a_err);
      end
    end
    tick();
    tests++;
    if (a_tc !== 8'd5 || a_tc !== tg[7:0]) begin
      fails++;
      $display("FAIL toggle_cnt: got %0d want 5", a_tc);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    mon_rstn = 0; mon_en = 0; mon_q = 0;
    tick();
    mon_rstn = 1;
    tick();
    mon_en = 1; mon_d = 1;
    for (int i = 0; i < 8; i++) tick();
    tests++;
    if (b_mc !== 2'd3 || b_st !== 1'b1) begin
      fails++;
      $display("FAIL saturate: got cnt=%0d st=%b want 3/1", b_mc, b_st);
    end
    tests++;
    if (a_mc !== mm1[7:0]) begin
      fails++;
      $display("FAIL nosat_a: got %0d want %0d", a_mc, mm1);
    end
    clr = 1;
    tick();
    clr = 0;
    tests++;
    if (b_mc !== 2'd0 || b_st !== 1'b0 || b_tc !== 2'd0) begin
      fails++;
      $display("FAIL clr: got cnt=%0d st=%b tc=%0d want 0/0/0",
               b_mc, b_st, b_tc);
    end
  endtask

  task automatic test_stop();
    do_reset();
    mon_rstn = 0; mon_en = 0; mon_q = 0;
    tick();
    mon_rstn = 1;
    tick();
    tick();
    mon_q = 1;
    tick();
    tests++;
    if (c_fail !== 1'b1 || c_mc !== 8'd1 || c_err !== 1'b1) begin
      fails++;
      $display("FAIL stop_enter: got fail=%b cnt=%0d err=%b want 1/1/1",
               c_fail, c_mc, c_err);
    end
    for (int i = 0; i < 10; i++) begin
      mon_en = ~mon_en;
      mon_d = i[0];
      mon_q = i[1];
      tick();
    end
    tests++;
    if (c_tc !== 8'd0 || c_mc !== 8'd1 || c_err !== 1'b0 ||
        c_exp !== 1'b0 || c_chk !== 1'b0) begin
      fails++;
      $display("FAIL stop_frozen: got tc=%0d mc=%0d err=%b exp=%b chk=%b",
               c_tc, c_mc, c_err, c_exp, c_chk);
    end
    do_reset();
    tests++;
    if (c_fail !== 1'b0) begin
      fails++;
      $display("FAIL stop_reset: got %b want 0", c_fail);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      mon_rstn = ($urandom_range(7) != 0);
      mon_en   = $urandom_range(1);
      mon_d    = $urandom_range(1);
      clr      = ($urandom_range(31) == 0);
      mon_q    = ($urandom_range(7) != 0) ? mv[n] : 1'($urandom_range(1));
      tick();
      tests++;
      if ({a_err, a_chk, a_exp, a_st} !== {er1, kna(n - 1), mva(n), st1}) begin
        fails++;
        $display("FAIL rnd_a_flags@%0d: got %b want %b", n,
                 {a_err, a_chk, a_exp, a_st}, {er1, kna(n - 1), mva(n), st1});
      end
      tests++;
      if (a_mc !== mm1[7:0] || a_tc !== tg[7:0]) begin
        fails++;
        $display("FAIL rnd_a_cnt@%0d: got %0d/%0d want %0d/%0d", n,
                 a_mc, a_tc, mm1, tg);
      end
      tests++;
      if ({e_err, e_chk, e_exp, e_st} !== {er3, kna(n - 3), mva(n - 2), st3}) begin
        fails++;
        $display("FAIL rnd_e_flags@%0d: got %b want %b", n,
                 {e_err, e_chk, e_exp, e_st}, {er3, kna(n - 3), mva(n - 2), st3});
      end
      tests++;
      if (e_mc !== mm3[7:0] || e_tc !== tg[7:0]) begin
        fails++;
        $display("FAIL rnd_e_cnt@%0d: got %0d/%0d want %0d/%0d", n,
                 e_mc, e_tc, mm3, tg);
      end
    end
    clr = 0;
  endtask

  initial begin
    test_reset();
    test_known();
    test_follow();
    test_toggle();
    test_saturate();
    test_stop();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
